// File: rtl/mem_arbiter.sv
// Two-requester (core / loader) arbiter in front of a single-port memory with
// fixed read latency. Round-robin arbitration, loader lock, in-order read return.
module mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {ARB, LOCKED} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t      state, state_nxt;
  logic        last_l;               // 1: loader was granted most recently
  logic [RD_LAT:0] vld_pipe;         // read in flight per stage
  logic [RD_LAT:0] tag_pipe;         // owner per stage, 1 = loader
  acc_t        c_acc, l_acc, sel;
  logic        any_gnt;

  assign c_acc   = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign l_acc   = '{we: l_we, addr: l_addr, wdata: l_wdata};
  assign any_gnt = c_gnt | l_gnt;
  assign sel     = l_gnt ? l_acc : c_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:    if (l_gnt && l_lock)  state_nxt = LOCKED;
      LOCKED: if (l_gnt && !l_lock) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grants are gated by reset so nothing is offered while rst_n is low.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (c_req && l_req) begin
            c_gnt = last_l;
            l_gnt = !last_l;
          end else begin
            c_gnt = c_req;
            l_gnt = l_req;
          end
        end
        LOCKED:  l_gnt = l_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_l    <= 1'b1;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
    end else begin
      mem_en    <= any_gnt;
      mem_we    <= any_gnt & sel.we;
      mem_addr  <= any_gnt ? sel.addr  : '0;
      mem_wdata <= any_gnt ? sel.wdata : '0;
      if (any_gnt) last_l <= l_gnt;
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], any_gnt & ~sel.we};
      tag_pipe  <= {tag_pipe[RD_LAT-1:0], l_gnt};
    end
  end

  assign c_rvalid = vld_pipe[RD_LAT] & ~tag_pipe[RD_LAT];
  assign l_rvalid = vld_pipe[RD_LAT] &  tag_pipe[RD_LAT];
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;
  assign busy     = (state == LOCKED) | (|vld_pipe);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant rules, shadow memory, return queue).
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic c_req, c_we, l_req, l_we, l_lock;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a fixed address pattern (0x10 -> 0xA5).
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a ^ 8'hB5;
  endfunction

  // Memory with RL-cycle read latency; junk on the bus when not reading.
  logic [DW-1:0] pmem [256];
  bit            pwr  [256];
  logic [DW-1:0] rd_d [RL];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_d[i] <= rd_d[i-1];
    if (mem_en && !mem_we) rd_d[0] <= pwr[mem_addr] ? pmem[mem_addr] : pat(mem_addr);
    else                   rd_d[0] <= DW'($urandom);
    if (mem_en && mem_we) begin
      pmem[mem_addr] <= mem_wdata;
      pwr[mem_addr]  <= 1'b1;
    end
  end
  assign mem_rdata = rd_d[RL-1];

  // Reference model: transaction-level view of grants and returned reads.
  typedef struct { int due; bit who; logic [DW-1:0] data; } rd_t;
  rd_t q[$];
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr  [256];
  int  cyc = 0;
  bit  m_locked = 0, m_last_l = 1;
  logic p_en = 0, p_we = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wd = '0;
  logic e_cg, e_lg, e_cv, e_lv, e_men, e_mwe, e_busy;
  logic [DW-1:0] e_crd, e_lrd, e_mwd;
  logic [AW-1:0] e_maddr;

  task automatic model_step();
    rd_t r;
    logic [AW-1:0] a;
    cyc++;
    {e_cg, e_lg, e_cv, e_lv, e_men, e_mwe, e_busy, e_crd, e_lrd, e_mwd, e_maddr} = '0;
    if (!rst_n) begin
      q.delete();
      m_locked = 0; m_last_l = 1;
      p_en = 0; p_we = 0; p_addr = '0; p_wd = '0;
      return;
    end
    if (m_locked)            begin e_cg = 0;        e_lg = l_req;     end
    else if (c_req && l_req) begin e_cg = m_last_l; e_lg = !m_last_l; end
    else                     begin e_cg = c_req;    e_lg = l_req;     end
    e_men = p_en; e_mwe = p_we; e_maddr = p_addr; e_mwd = p_wd;
    e_busy = m_locked || (q.size() != 0);
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.who) begin e_lv = 1; e_lrd = r.data; end
      else       begin e_cv = 1; e_crd = r.data; end
    end
    p_en = e_cg | e_lg;
    p_we = 0; p_addr = '0; p_wd = '0;
    if (p_en) begin
      p_we   = e_lg ? l_we : c_we;
      p_addr = e_lg ? l_addr : c_addr;
      p_wd   = e_lg ? l_wdata : c_wdata;
      a = p_addr;
      if (p_we) begin ref_mem[a] = p_wd; ref_wr[a] = 1; end
      else begin
        r.due = cyc + 1 + RL; r.who = e_lg;
        r.data = ref_wr[a] ? ref_mem[a] : pat(a);
        q.push_back(r);
      end
      m_last_l = e_lg;
    end
    if (e_lg) m_locked = l_lock;
  endtask

  task automatic samp();
    @(negedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin samp(); tick(); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    c_req = 1; c_we = 0; c_addr = 8'h11; c_wdata = '0;
    l_req = 1; l_we = 0; l_lock = 0; l_addr = 8'h22; l_wdata = '0;
    samp();
    checks++;
    if ({c_gnt, l_gnt, c_rvalid, l_rvalid, c_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rv=%b%b mem_en=%b busy=%b, want all 0", c_gnt, l_gnt, c_rvalid, l_rvalid, mem_en, busy);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    for (int i = 0; i < 4; i++) begin
      samp();
      checks++;
      if (c_gnt !== 1'(i % 2 == 0) || l_gnt !== 1'(i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got c=%b l=%b want c=%b l=%b", i, c_gnt, l_gnt, i % 2 == 0, i % 2 == 1);
      end
      if (i > 0) begin
        ea = (i % 2 == 1) ? 8'h11 : 8'h22;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== ea) begin
          errors++;
          $display("FAIL rr_mem[%0d]: got en=%b addr=%h want en=1 addr=%h", i, mem_en, mem_addr, ea);
        end
      end
      tick();
      if (i == 3) begin c_req = 0; l_req = 0; end
    end
    samp();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h22) begin
      errors++;
      $display("FAIL rr_mem_last: got en=%b addr=%h want en=1 addr=22", mem_en, mem_addr);
    end
    tick();
    idle(4);
  endtask

  task automatic test_single_read();
    c_req = 1; c_we = 0; c_addr = 8'h10;
    samp();
    checks++;
    if (c_gnt !== 1'b1 || l_gnt !== 1'b0) begin
      errors++; $display("FAIL rd_gnt: got c=%b l=%b want c=1 l=0", c_gnt, l_gnt);
    end
    tick(); c_req = 0;
    samp();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || c_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_cmd: got en=%b we=%b addr=%h rv=%b want 1 0 10 0", mem_en, mem_we, mem_addr, c_rvalid);
    end
    tick(); samp();
    checks++;
    if (c_rvalid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rd_early: got rv=%b busy=%b want rv=0 busy=1", c_rvalid, busy);
    end
    tick(); samp();
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5 || l_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_data: got rv=%b data=%h lrv=%b want rv=1 data=a5 lrv=0", c_rvalid, c_rdata, l_rvalid);
    end
    tick(); samp();
    checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_after: got rv=%b data=%h busy=%b want 0 00 0", c_rvalid, c_rdata, busy);
    end
    tick();
  endtask

  task automatic test_lock();
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 8'h40; l_wdata = 8'h01;
    samp();
    checks++;
    if (l_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      errors++; $display("FAIL lock_first: got c=%b l=%b want c=0 l=1", c_gnt, l_gnt);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      c_req = 1; c_we = 0; c_addr = 8'h40;
      l_addr = 8'h41 + AW'(k); l_wdata = 8'h02 + DW'(k);
      l_req = (k != 1); l_lock = (k != 1) && (k != 3);
      samp();
      checks++;
      if (c_gnt !== 1'b0 || l_gnt !== 1'(k != 1) || busy !== 1'b1) begin
        errors++; $display("FAIL lock_hold[%0d]: got c=%b l=%b busy=%b want c=0 l=%b busy=1", k, c_gnt, l_gnt, busy, k != 1);
      end
    end
    tick(); l_req = 0;
    samp();
    checks++;
    if (c_gnt !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lock_release: got c=%b busy=%b want c=1 busy=0", c_gnt, busy);
    end
    tick(); c_req = 0;
    samp(); tick(); samp(); tick(); samp();
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 8'h01) begin
      errors++; $display("FAIL lock_readback: got rv=%b data=%h want rv=1 data=01", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_raw();
    l_req = 1; l_we = 1; l_lock = 0; l_addr = 8'h20; l_wdata = 8'h3C;
    samp();
    checks++;
    if (l_gnt !== 1'b1) begin errors++; $display("FAIL raw_wgnt: got %b want 1", l_gnt); end
    tick(); l_req = 0; c_req = 1; c_we = 0; c_addr = 8'h20;
    samp();
    checks++;
    if (c_gnt !== 1'b1) begin errors++; $display("FAIL raw_rgnt: got %b want 1", c_gnt); end
    tick(); c_req = 0;
    samp(); tick(); samp(); tick(); samp();
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 8'h3C) begin
      errors++; $display("FAIL raw_data: got rv=%b data=%h want rv=1 data=3c", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic cg, lg, prev;
    c_req = 1; c_we = 0; c_addr = 8'h50;
    l_req = 1; l_we = 0; l_lock = 0; l_addr = 8'h60;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      samp();
      cg = c_gnt; lg = l_gnt;
      checks++;
      if (!(cg ^ lg) || (i > 0 && cg === prev)) begin
        errors++; $display("FAIL b2b_alt[%0d]: got c=%b l=%b prev_c=%b", i, cg, lg, prev);
      end
      if (i > 0) begin
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL b2b_bubble[%0d]: got mem_en=%b want 1", i, mem_en); end
      end
      checks++;
      if ({c_rvalid, l_rvalid, c_rdata, l_rdata} !== {e_cv, e_lv, e_crd, e_lrd}) begin
        errors++;
        $display("FAIL b2b_ret[%0d]: got rv=%b%b d=%h/%h want rv=%b%b d=%h/%h", i, c_rvalid, l_rvalid, c_rdata, l_rdata, e_cv, e_lv, e_crd, e_lrd);
      end
      prev = cg;
      tick();
      if (cg) c_addr = c_addr + 1;
      if (lg) l_addr = l_addr + 1;
    end
    c_req = 0; l_req = 0;
    for (int i = 0; i < RL + 2; i++) begin
      samp();
      checks++;
      if ({c_rvalid, l_rvalid, c_rdata, l_rdata} !== {e_cv, e_lv, e_crd, e_lrd}) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: got rv=%b%b d=%h/%h want rv=%b%b d=%h/%h", i, c_rvalid, l_rvalid, c_rdata, l_rdata, e_cv, e_lv, e_crd, e_lrd);
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    c_req = 1; c_we = 0; c_addr = 8'h30;
    samp();
    checks++;
    if (c_gnt !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: got %b want 1", c_gnt); end
    tick(); c_req = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({c_gnt, l_gnt, c_rvalid, l_rvalid, c_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      errors++; $display("FAIL rst_async: got mem_en=%b addr=%h busy=%b want all 0", mem_en, mem_addr, busy);
    end
    samp(); tick();
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      samp();
      checks++;
      if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_ghost[%0d]: got rv=%b%b busy=%b want 0", i, c_rvalid, l_rvalid, busy);
      end
      tick();
    end
    c_req = 1; c_addr = 8'h31;
    samp();
    checks++;
    if (c_gnt !== 1'b1) begin errors++; $display("FAIL rst_resume: got %b want 1", c_gnt); end
    tick(); c_req = 0;
    samp();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h31) begin
      errors++; $display("FAIL rst_resume_cmd: got en=%b addr=%h want 1 31", mem_en, mem_addr);
    end
    tick();
    idle(4);
  endtask

  task automatic test_random();
    logic cg = 0, lg = 0;
    for (int i = 0; i < 400; i++) begin
      if (!c_req || cg) begin
        c_req = ($urandom_range(0, 2) != 0); c_we = 1'($urandom);
        c_addr = AW'($urandom_range(0, 15)); c_wdata = DW'($urandom);
      end
      if (!l_req || lg) begin
        l_req = ($urandom_range(0, 2) != 0); l_we = 1'($urandom);
        l_lock = ($urandom_range(0, 3) == 0);
        l_addr = AW'($urandom_range(0, 15)); l_wdata = DW'($urandom);
      end
      samp();
      cg = c_gnt; lg = l_gnt;
      checks++;
      if ({c_gnt, l_gnt, c_rvalid, l_rvalid, c_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !==
          {e_cg, e_lg, e_cv, e_lv, e_crd, e_lrd, e_men, e_mwe, e_maddr, e_mwd, e_busy}) begin
        errors++;
        $display("FAIL rand[%0d]: got gnt=%b%b rv=%b%b d=%h/%h mem=%b%b %h %h busy=%b want gnt=%b%b rv=%b%b d=%h/%h mem=%b%b %h %h busy=%b",
                 i, c_gnt, l_gnt, c_rvalid, l_rvalid, c_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy,
                 e_cg, e_lg, e_cv, e_lv, e_crd, e_lrd, e_men, e_mwe, e_maddr, e_mwd, e_busy);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_lock();
    test_raw();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
